fios_mm_sched: RTL

- Control sequencer for the unfolded (EXPAND) FIOS Montgomery multiplier array of PE_NB processing elements.
- On a start request it generates every per-PE control bus (operand register enables, mux selects, OPMODE, C/RES enables) and the b/p word index for the operand feed.
- Each PE runs an identical local schedule, staggered by PE_DELAY cycles per PE index.
- Signals completion with a done pulse and flags result words as they leave the last PE.

---
 rtl/fios_mm_sched.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/fios_mm_sched.sv
// Control sequencer for the unfolded FIOS Montgomery multiplier array.
// One local schedule per PE, staggered by PE_DELAY; outputs are registered.
module fios_mm_sched #(
  parameter int s = 8,
  parameter int PE_DELAY = 7,
  parameter int DRAIN_CYC = 4,
  parameter int RES_LAT = 3,
  parameter logic [8:0] OPM_IDLE = 9'h000,
  parameter logic [8:0] OPM_AB0 = 9'h005,
  parameter logic [8:0] OPM_M = 9'h005,
  parameter logic [8:0] OPM_AB = 9'h035,
  parameter logic [8:0] OPM_MP = 9'h0B5
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [$clog2(s)-1:0] word_idx_o,
  output logic                 res_valid_o,
  output logic [$clog2(s)-1:0] res_idx_o,
  output logic [s-1:0]         a_reg_en_o,
  output logic [s-1:0]         m_reg_en_o,
  output logic [s-1:0]         CREG_en_o,
  output logic [s-1:0]         RES_delay_en_o,
  output logic [s-1:0]         C_input_delay_en_o,
  output logic [2*s-1:0]       mux_A_sel_o,
  output logic [2*s-1:0]       mux_B_sel_o,
  output logic [2*s-1:0]       mux_C_sel_o,
  output logic [9*s-1:0]       OPMODE_o
);

  localparam int PE_NB = s;
  localparam int T = 2 * s + 2;
  localparam int LAST_OFF = (PE_NB - 1) * PE_DELAY;
  localparam int RUN_LAST = LAST_OFF + T - 1;
  localparam int DRN_LAST = RUN_LAST + DRAIN_CYC;
  localparam int GW = $clog2(DRN_LAST + 2);
  localparam int IW = $clog2(s);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t st, st_n;
  logic [GW-1:0] g, g_n;

  always_comb begin
    st_n = st;
    g_n = g;
    unique case (st)
      IDLE: begin
        if (start_i) begin
          st_n = RUN;
          g_n = '0;
        end
      end
      RUN: begin
        g_n = g + 1'b1;
        if (g == GW'(RUN_LAST)) st_n = DRAIN;
      end
      DRAIN: begin
        g_n = g + 1'b1;
        if (g == GW'(DRN_LAST)) st_n = DONE;
      end
      DONE: begin
        st_n = IDLE;
        g_n = '0;
      end
      default: begin
        st_n = IDLE;
        g_n = '0;
      end
    endcase
  end

  logic            run_n;
  logic [s-1:0]    a_n, m_n, c_n, r_n, ci_n;
  logic [2*s-1:0]  ma_n, mb_n, mc_n;
  logic [9*s-1:0]  op_n;
  logic [IW-1:0]   widx_n;
  int              t;

  // Decode the step each PE will be at on the coming cycle.
  always_comb begin
    run_n = (st_n == RUN);
    a_n = '0;
    m_n = '0;
    c_n = '0;
    r_n = '0;
    ci_n = '0;
    ma_n = '0;
    mb_n = '0;
    mc_n = '0;
    op_n = {PE_NB{OPM_IDLE}};
    widx_n = '0;
    t = 0;
    for (int i = 0; i < PE_NB; i++) begin
      t = int'(g_n) - i * PE_DELAY;
      if (run_n && t >= 0 && t < T) begin
        unique case (1'b1)
          (t == 0): begin
            a_n[i] = 1'b1;
            mc_n[2*i +: 2] = 2'd1;
            op_n[9*i +: 9] = OPM_AB0;
          end
          (t == 1): begin
            m_n[i] = 1'b1;
            ma_n[2*i +: 2] = 2'd1;
            mb_n[2*i +: 2] = 2'd1;
            op_n[9*i +: 9] = OPM_M;
          end
          (t >= 2 && t[0] == 1'b0): begin
            c_n[i] = 1'b1;
            ci_n[i] = 1'b1;
            mc_n[2*i +: 2] = 2'd2;
            op_n[9*i +: 9] = OPM_AB;
          end
          (t >= 3 && t[0] == 1'b1): begin
            ma_n[2*i +: 2] = 2'd2;
            mb_n[2*i +: 2] = 2'd2;
            op_n[9*i +: 9] = OPM_MP;
            r_n[i] = (t >= 5);
          end
          default: ;
        endcase
      end
    end
    if (run_n && int'(g_n) >= 2 && int'(g_n) < T)
      widx_n = IW'((int'(g_n) - 2) / 2);
  end

  logic [RES_LAT-1:0] pv;
  logic [IW-1:0]      pidx [RES_LAT];
  logic               src_v;
  logic [IW-1:0]      src_idx;
  int                 ri;

  // The last PE's result step is visible on the registered enable now.
  always_comb begin
    src_v = RES_delay_en_o[PE_NB-1];
    ri = (int'(g) - LAST_OFF - 5) / 2;
    src_idx = src_v ? IW'(ri) : '0;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      st <= IDLE;
      g <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      word_idx_o <= '0;
      a_reg_en_o <= '0;
      m_reg_en_o <= '0;
      CREG_en_o <= '0;
      RES_delay_en_o <= '0;
      C_input_delay_en_o <= '0;
      mux_A_sel_o <= '0;
      mux_B_sel_o <= '0;
      mux_C_sel_o <= '0;
      OPMODE_o <= {PE_NB{OPM_IDLE}};
      pv <= '0;
      for (int k = 0; k < RES_LAT; k++) pidx[k] <= '0;
    end else begin
      st <= st_n;
      g <= g_n;
      busy_o <= (st_n == RUN) || (st_n == DRAIN);
      done_o <= (st_n == DONE);
      word_idx_o <= widx_n;
      a_reg_en_o <= a_n;
      m_reg_en_o <= m_n;
      CREG_en_o <= c_n;
      RES_delay_en_o <= r_n;
      C_input_delay_en_o <= ci_n;
      mux_A_sel_o <= ma_n;
      mux_B_sel_o <= mb_n;
      mux_C_sel_o <= mc_n;
      OPMODE_o <= op_n;
      pv[0] <= src_v;
      pidx[0] <= src_idx;
      for (int k = 1; k < RES_LAT; k++) begin
        pv[k] <= pv[k-1];
        pidx[k] <= pidx[k-1];
      end
    end
  end

  assign res_valid_o = pv[RES_LAT-1];
  assign res_idx_o = pidx[RES_LAT-1];

endmodule
